// File: rtl/accumulator_requantizer.sv
// accumulator_requantizer: narrows unsigned accumulator results to activations.
//   out = saturate((in_data * scale) >> shift), two-stage valid/ready pipeline.
// Optional build macro REQUANT_ROUND_EN selects round-half-up before the shift;
// without it the shift truncates.
module accumulator_requantizer #(
    parameter int DATA_WIDTH  = 8,
    parameter int ACC_WIDTH   = 16,
    parameter int SCALE_WIDTH = 8,
    parameter int SHIFT_WIDTH = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [ACC_WIDTH-1:0]   in_data,
    input  logic [SCALE_WIDTH-1:0] scale,
    input  logic [SHIFT_WIDTH-1:0] shift,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [DATA_WIDTH-1:0]  out_data,
    output logic                   out_sat
);

    localparam int PW = ACC_WIDTH + SCALE_WIDTH;

    logic [PW-1:0]          s1_prod;
    logic [SHIFT_WIDTH-1:0] s1_shift;
    logic                   s1_valid;

    logic                   s2_free;
    logic                   s1_adv;
    logic                   accept;

    // One extra bit so the rounding increment can never wrap the product.
    logic [PW:0]            rnd_sum;
    logic [PW:0]            q;
    logic                   q_sat;
    logic [DATA_WIDTH-1:0]  q_clamped;

    assign s2_free  = !out_valid || out_ready;
    assign s1_adv   = s1_valid && s2_free;
    // Gated with rst_n so nothing is accepted while held in reset.
    assign in_ready = rst_n && (!s1_valid || s2_free);
    assign accept   = in_valid && in_ready;

    // Stage 1: capture the full-width product and this item's shift.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_prod  <= '0;
            s1_shift <= '0;
            s1_valid <= 1'b0;
        end else begin
            if (accept) begin
                s1_prod  <= PW'(in_data) * PW'(scale);
                s1_shift <= shift;
            end
            if (accept)
                s1_valid <= 1'b1;
            else if (s1_adv)
                s1_valid <= 1'b0;
        end
    end

    // Shift (optionally rounded) and clamp to the activation range.
    always_comb begin
        rnd_sum = {1'b0, s1_prod};
`ifdef REQUANT_ROUND_EN
        if (s1_shift != '0)
            rnd_sum = {1'b0, s1_prod} + ((PW+1)'(1) << (s1_shift - 1'b1));
`endif
        q         = rnd_sum >> s1_shift;
        q_sat     = |q[PW:DATA_WIDTH];
        q_clamped = q_sat ? {DATA_WIDTH{1'b1}} : q[DATA_WIDTH-1:0];
    end

    // Stage 2: output registers; data only loads on an advance so it holds
    // during stalls and keeps its last value once the output goes idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_sat   <= 1'b0;
        end else if (s2_free) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                out_data <= q_clamped;
                out_sat  <= q_sat;
            end
        end
    end

endmodule
